// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults and halt-state encoding for the register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_NREG     = 32;
    localparam int          DEF_NRD      = 2;
    localparam int          DEF_SP_IDX   = 2;
    localparam logic [31:0] DEF_SP_INIT  = 32'h0000_2ffc;
    localparam int          DEF_HALT_REG = 17;
    localparam logic [31:0] DEF_HALT_VAL = 32'd10;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-register pending-producer bits with write-through masking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              byp_en,
    input  logic [AW-1:0]     byp_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] busy;

    // Set is applied after clear so a new producer supersedes a retiring one.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != '0)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd_busy
        logic [AW-1:0] addr;
        assign addr       = rd_addr[i*AW +: AW];
        assign rd_busy[i] = busy[addr] && !(byp_en && (byp_addr == addr));
    end

endmodule

`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
// ============================================================================
// Module   : regfile_bypass_sb
// Purpose  : Register file with write-through bypass, scoreboard and halt FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int               XLEN     = DEF_XLEN,
    parameter int               NREG     = DEF_NREG,
    parameter int               NRD      = DEF_NRD,
    parameter int               SP_IDX   = DEF_SP_IDX,
    parameter logic [XLEN-1:0]  SP_INIT  = XLEN'(DEF_SP_INIT),
    parameter int               HALT_REG = DEF_HALT_REG,
    parameter logic [XLEN-1:0]  HALT_VAL = XLEN'(DEF_HALT_VAL),
    localparam int              AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                ecall,
    output logic                is_halted,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    localparam logic [AW-1:0] HALT_ADDR = AW'(HALT_REG);

    logic [XLEN-1:0] regs [NREG];
    halt_state_e     state;
    halt_state_e     state_next;
    logic            halted;
    logic            commit;
    logic [XLEN-1:0] halt_value;
    logic            halt_busy;
    logic [NRD:0]    busy_all;

    assign halted    = (state == ST_HALTED);
    assign is_halted = halted;
    assign commit    = wr_en && (wr_addr != '0) && !halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] = (addr == '0)                   ? '0      :
                                         (wr_en && (wr_addr == addr))   ? wr_data :
                                                                          regs[addr];
    end

    assign dbg_data = regs[dbg_addr];

    // The halt register rides on an extra scoreboard port so its busy view
    // gets the same write-through masking as the architectural read ports.
    reg_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD + 1)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (alloc_en && !halted),
        .set_addr (alloc_addr),
        .clr_en   (commit),
        .clr_addr (wr_addr),
        .rd_addr  ({HALT_ADDR, rd_addr}),
        .byp_en   (wr_en),
        .byp_addr (wr_addr),
        .rd_busy  (busy_all)
    );

    assign rd_busy   = busy_all[NRD-1:0];
    assign halt_busy = busy_all[NRD];

    assign halt_value = (HALT_ADDR == '0)                     ? '0      :
                        (wr_en && (wr_addr == HALT_ADDR))     ? wr_data :
                                                                regs[HALT_ADDR];

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (ecall && (halt_value == HALT_VAL) && !halt_busy) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
// ============================================================================
// Module   : tb_regfile_bypass_sb
// Purpose  : Directed and random checks of regfile_bypass_sb against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        ecall;
    logic        is_halted;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    // Wide three-port build
    logic [14:0]  w_rd_addr;
    logic [191:0] w_rd_data;
    logic [2:0]   w_rd_busy;
    logic         w_wr_en;
    logic [4:0]   w_wr_addr;
    logic [63:0]  w_wr_data;
    logic         w_alloc_en;
    logic [4:0]   w_alloc_addr;
    logic         w_ecall;
    logic         w_is_halted;
    logic [4:0]   w_dbg_addr;
    logic [63:0]  w_dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb u_dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ecall      (ecall),
        .is_halted  (is_halted),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    regfile_bypass_sb #(.XLEN(64), .NRD(3)) u_dut_wide (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (w_rd_addr),
        .rd_data    (w_rd_data),
        .rd_busy    (w_rd_busy),
        .wr_en      (w_wr_en),
        .wr_addr    (w_wr_addr),
        .wr_data    (w_wr_data),
        .alloc_en   (w_alloc_en),
        .alloc_addr (w_alloc_addr),
        .ecall      (w_ecall),
        .is_halted  (w_is_halted),
        .dbg_addr   (w_dbg_addr),
        .dbg_data   (w_dbg_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default build ----------------
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic        m_halted;
    logic        m_ok = 1'b0;
    logic [31:0] m_v17;
    logic        m_b17;
    logic        m_go;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_regs[2] = 32'h2ffc;
            m_halted  = 1'b0;
            m_ok      = 1'b1;
        end else if (m_ok && !m_halted) begin
            m_v17 = exp_rd(5'd17);
            m_b17 = exp_busy(5'd17);
            m_go  = ecall && (m_v17 == 32'd10) && !m_b17;
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
            m_halted = m_go;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rd_data%0d", i), {32'd0, rd_data[i*32 +: 32]},
                      {32'd0, exp_rd(rd_addr[i*5 +: 5])});
                check($sformatf("rd_busy%0d", i), {63'd0, rd_busy[i]},
                      {63'd0, exp_busy(rd_addr[i*5 +: 5])});
            end
            check("is_halted", {63'd0, is_halted}, {63'd0, m_halted});
            check("dbg_data", {32'd0, dbg_data}, {32'd0, m_regs[dbg_addr]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        alloc_en = 1'b0;
        ecall    = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    function automatic logic [4:0] rnd_addr();
        case ($urandom % 8)
            0:       return 5'd0;
            1:       return 5'd2;
            2:       return 5'd5;
            3:       return 5'd7;
            4, 5:    return 5'd17;
            default: return 5'($urandom % 32);
        endcase
    endfunction

    initial begin
        reset = 1'b1; rd_addr = '0; dbg_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
        idle();
        w_rd_addr = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_alloc_en = 1'b0; w_alloc_addr = '0; w_ecall = 1'b0; w_dbg_addr = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset values
        rd_addr = {5'd0, 5'd2}; #2;
        check("rst_x2", {32'd0, rd_data[31:0]}, 64'h2ffc);
        check("rst_x0", {32'd0, rd_data[63:32]}, 64'h0);
        check("rst_busy", {62'd0, rd_busy}, 64'h0);
        check("rst_halt", {63'd0, is_halted}, 64'h0);

        // Write-through bypass, debug port unbypassed, x0 discards writes
        wr(5'd5, 32'hDEAD_BEEF); rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5; #2;
        check("byp_x5", {32'd0, rd_data[31:0]}, 64'hDEAD_BEEF);
        check("dbg_old_x5", {32'd0, dbg_data}, 64'h0);
        tick(); idle(); #2;
        check("dbg_new_x5", {32'd0, dbg_data}, 64'hDEAD_BEEF);
        wr(5'd0, 32'd123); rd_addr = '0; dbg_addr = 5'd0; #2;
        check("byp_x0", {32'd0, rd_data[31:0]}, 64'h0);
        tick(); idle(); #2;
        check("dbg_x0", {32'd0, dbg_data}, 64'h0);

        // Scoreboard set / clear / alloc-beats-write
        alloc_en = 1'b1; alloc_addr = 5'd7; tick(); idle();
        rd_addr = {5'd0, 5'd7}; #2;
        check("busy_x7", {63'd0, rd_busy[0]}, 64'h1);
        tick(); wr(5'd7, 32'd3); #2;
        check("busy_x7_byp", {63'd0, rd_busy[0]}, 64'h0);
        check("data_x7_byp", {32'd0, rd_data[31:0]}, 64'h3);
        tick(); idle(); #2;
        check("busy_x7_clr", {63'd0, rd_busy[0]}, 64'h0);
        wr(5'd7, 32'd4); alloc_en = 1'b1; alloc_addr = 5'd7; tick(); idle(); #2;
        check("busy_x7_alloc_wr", {63'd0, rd_busy[0]}, 64'h1);
        check("data_x7_alloc_wr", {32'd0, rd_data[31:0]}, 64'h4);

        // ecall blocked by busy, then by wrong value, then halts via bypass
        wr(5'd17, 32'd10); tick(); idle();
        alloc_en = 1'b1; alloc_addr = 5'd17; tick(); idle();
        ecall = 1'b1; tick(); idle(); #2;
        check("nohalt_busy", {63'd0, is_halted}, 64'h0);
        wr(5'd17, 32'd9); tick(); idle();
        ecall = 1'b1; tick(); idle(); #2;
        check("nohalt_val", {63'd0, is_halted}, 64'h0);
        wr(5'd17, 32'd10); ecall = 1'b1; tick(); idle(); #2;
        check("halt_byp", {63'd0, is_halted}, 64'h1);

        // Halted: writes and allocs ignored
        wr(5'd8, 32'd1); alloc_en = 1'b1; alloc_addr = 5'd9;
        dbg_addr = 5'd8; rd_addr = {5'd9, 5'd8}; tick(); idle(); #2;
        check("halt_x8", {32'd0, rd_data[31:0]}, 64'h0);
        check("halt_dbg_x8", {32'd0, dbg_data}, 64'h0);
        check("halt_busy_x9", {63'd0, rd_busy[1]}, 64'h0);
        check("halt_sticky", {63'd0, is_halted}, 64'h1);
        reset = 1'b1; tick(); reset = 1'b0; #2;
        check("halt_reset", {63'd0, is_halted}, 64'h0);

        // Plain halt with one-cycle latency
        wr(5'd17, 32'd10); tick(); idle();
        ecall = 1'b1; #2;
        check("halt_lat0", {63'd0, is_halted}, 64'h0);
        tick(); idle(); #2;
        check("halt_lat1", {63'd0, is_halted}, 64'h1);
        tick(); #2;
        check("halt_lat2", {63'd0, is_halted}, 64'h1);
        reset = 1'b1; tick(); reset = 1'b0;

        // Wide build: x1/x2/x3 with concurrent write to x3
        w_wr_en = 1'b1; w_wr_addr = 5'd1; w_wr_data = 64'h1111_2222_3333_4444; tick();
        w_wr_addr = 5'd3; w_wr_data = 64'hAAAA_BBBB_CCCC_DDDD; tick();
        w_wr_data = 64'h5555_6666_7777_8888; w_rd_addr = {5'd3, 5'd2, 5'd1}; w_dbg_addr = 5'd3; #2;
        check("w_port0", w_rd_data[63:0], 64'h1111_2222_3333_4444);
        check("w_port1", w_rd_data[127:64], 64'h2ffc);
        check("w_port2", w_rd_data[191:128], 64'h5555_6666_7777_8888);
        check("w_dbg_old", w_dbg_data, 64'hAAAA_BBBB_CCCC_DDDD);
        tick(); w_wr_en = 1'b0; #2;
        check("w_port2_commit", w_rd_data[191:128], 64'h5555_6666_7777_8888);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            reset      = ($urandom % 80 == 0);
            wr_en      = $urandom % 2;
            wr_addr    = rnd_addr();
            case ($urandom % 4)
                0:       wr_data = 32'd10;
                1:       wr_data = 32'd9;
                default: wr_data = $urandom;
            endcase
            alloc_en   = ($urandom % 4 == 0);
            alloc_addr = rnd_addr();
            ecall      = ($urandom % 12 == 0);
            rd_addr    = {rnd_addr(), rnd_addr()};
            dbg_addr   = rnd_addr();
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
